// File: rtl/hazard_sb_pkg.sv
// Shared widths, forwarding-select encodings and MDU scoreboard state for hazard_sb.
package hazard_pkg;
  localparam int REG_W = 5;

  typedef logic [1:0] fwd_t;
  localparam fwd_t FWD_NONE = 2'b00;
  localparam fwd_t FWD_M    = 2'b10;
  localparam fwd_t FWD_W    = 2'b01;

  // HI/LO selects use the opposite bit order from the GPR selects
  localparam fwd_t HL_NONE = 2'b00;
  localparam fwd_t HL_M    = 2'b01;
  localparam fwd_t HL_W    = 2'b10;

  typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_e;
endpackage

// File: rtl/hazard_sb_mdu.sv
// Multiply/divide latency scoreboard: holds E stalled until the MDU result is ready.
module mdu_stall_ctr import hazard_pkg::*; #(
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic div,
  input  logic abort,
  output logic stall,
  output logic busy
);
  localparam int MAX_LAT = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);

  mdu_state_e state, stateNxt;
  logic [CNT_W-1:0] cnt, cntNxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    if (abort) begin
      stateNxt = MDU_IDLE;
      cntNxt   = '0;
    end else begin
      case (state)
        MDU_IDLE: if (start) begin
          stateNxt = MDU_BUSY;
          cntNxt   = div ? DIV_LD : MUL_LD;
        end
        MDU_BUSY: if (cnt == '0) stateNxt = MDU_DONE;
                  else           cntNxt   = cnt - 1'b1;
        MDU_DONE: stateNxt = MDU_IDLE;
        default:  stateNxt = MDU_IDLE;
      endcase
    end
  end

  // DONE releases the stall so the finished op can advance to M
  always_comb begin
    stall = start && (state != MDU_DONE);
    busy  = (state != MDU_IDLE);
  end
endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard/forwarding controller: per-slot comparators, MDU scoreboard, stall/flush priority.
module hazard_sb import hazard_pkg::*; #(
  parameter int NUM_SRC    = 2,
  parameter int DIV_CYCLES = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_W*NUM_SRC-1:0] SrcD,
  input  logic [REG_W*NUM_SRC-1:0] SrcE,
  input  logic                     BranchD,
  input  logic [REG_W-1:0]         WriteRegE,
  input  logic [REG_W-1:0]         WriteRegM,
  input  logic [REG_W-1:0]         WriteRegW,
  input  logic                     RegWriteE,
  input  logic                     RegWriteM,
  input  logic                     RegWriteW,
  input  logic                     LoadE,
  input  logic                     LoadM,
  input  logic                     MfhiE,
  input  logic                     MfloE,
  input  logic                     HIWriteM,
  input  logic                     HIWriteW,
  input  logic                     LOWriteM,
  input  logic                     LOWriteW,
  input  logic                     MduStartE,
  input  logic                     MduDivE,
  input  logic                     ExcM,
  output logic                     StallF,
  output logic                     StallD,
  output logic                     StallE,
  output logic                     FlushD,
  output logic                     FlushE,
  output logic                     FlushM,
  output logic [NUM_SRC-1:0]       ForwardD,
  output logic [2*NUM_SRC-1:0]     ForwardE,
  output logic [1:0]               ForwardHIE,
  output logic [1:0]               ForwardLOE,
  output logic                     MduBusy
);
  logic [NUM_SRC-1:0] luHit, brHit;
  logic lus, brs, mds;

  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : gSrc
      logic [REG_W-1:0] sD, sE;
      fwd_t fe;
      assign sD = SrcD[REG_W*i +: REG_W];
      assign sE = SrcE[REG_W*i +: REG_W];

      assign ForwardD[i] = (sD != '0) && (sD == WriteRegM) && RegWriteM;

      always_comb begin
        fe = FWD_NONE;
        if (sE != '0) begin
          if (sE == WriteRegM && RegWriteM)      fe = FWD_M;
          else if (sE == WriteRegW && RegWriteW) fe = FWD_W;
        end
      end
      assign ForwardE[2*i +: 2] = fe;

      assign luHit[i] = (sD == WriteRegE);
      assign brHit[i] = (sD != '0) &&
                        ((sD == WriteRegE && RegWriteE) || (sD == WriteRegM && LoadM));
    end
  endgenerate

  assign lus = LoadE && (WriteRegE != '0) && (|luHit);
  assign brs = BranchD && (|brHit);

  always_comb begin
    ForwardHIE = HL_NONE;
    ForwardLOE = HL_NONE;
    if (MfhiE) begin
      if (HIWriteM)      ForwardHIE = HL_M;
      else if (HIWriteW) ForwardHIE = HL_W;
    end
    if (MfloE) begin
      if (LOWriteM)      ForwardLOE = HL_M;
      else if (LOWriteW) ForwardLOE = HL_W;
    end
  end

  mdu_stall_ctr #(.DIV_CYCLES(DIV_CYCLES), .MUL_CYCLES(MUL_CYCLES)) uMdu (
    .clk   (clk),
    .rst   (rst),
    .start (MduStartE),
    .div   (MduDivE),
    .abort (ExcM),
    .stall (mds),
    .busy  (MduBusy)
  );

  // LuS/BrS are masked under MdS; they re-evaluate once the MDU releases E
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (ExcM) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else if (mds) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (lus || brs) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_sb.sv
// Scoreboard bench for hazard_sb: expectations queued at drive time, compared mid-cycle.
module tb_hazard_sb;
  localparam int NS = 3, DC = 32, MC = 4;

  // ctl = {StallF,StallD,StallE,FlushD,FlushE,FlushM,MduBusy}
  localparam logic [6:0] IDL  = 7'b000_000_0;
  localparam logic [6:0] MDS0 = 7'b111_001_0;
  localparam logic [6:0] MDSB = 7'b111_001_1;
  localparam logic [6:0] HAZ  = 7'b110_010_0;
  localparam logic [6:0] HAZB = 7'b110_010_1;
  localparam logic [6:0] EXCB = 7'b000_111_1;
  localparam logic [6:0] BSY  = 7'b000_000_1;

  logic clk = 1'b0, rst;
  logic [5*NS-1:0] SrcD, SrcE;
  logic BranchD, RegWriteE, RegWriteM, RegWriteW, LoadE, LoadM, MfhiE, MfloE;
  logic HIWriteM, HIWriteW, LOWriteM, LOWriteW, MduStartE, MduDivE, ExcM;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy;
  logic [NS-1:0] ForwardD;
  logic [2*NS-1:0] ForwardE;
  logic [1:0] ForwardHIE, ForwardLOE;

  hazard_sb #(.NUM_SRC(NS), .DIV_CYCLES(DC), .MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .SrcD(SrcD), .SrcE(SrcE), .BranchD(BranchD),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .LoadM(LoadM), .MfhiE(MfhiE), .MfloE(MfloE),
    .HIWriteM(HIWriteM), .HIWriteW(HIWriteW), .LOWriteM(LOWriteM), .LOWriteW(LOWriteW),
    .MduStartE(MduStartE), .MduDivE(MduDivE), .ExcM(ExcM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardD(ForwardD), .ForwardE(ForwardE),
    .ForwardHIE(ForwardHIE), .ForwardLOE(ForwardLOE), .MduBusy(MduBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [6:0]    ctl;
    logic [NS-1:0] fd;
    logic [2*NS-1:0] fe;
    logic [1:0]    hi;
    logic [1:0]    lo;
  } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : scoreChk
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".ctl"}, {25'd0, StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy}, {25'd0, e.ctl});
      chk({e.tag, ".fwdD"}, 32'(ForwardD), 32'(e.fd));
      chk({e.tag, ".fwdE"}, 32'(ForwardE), 32'(e.fe));
      chk({e.tag, ".hilo"}, {28'd0, ForwardHIE, ForwardLOE}, {28'd0, e.hi, e.lo});
    end
  end

  // Queue the expectation for the inputs just driven, then advance one cycle
  task automatic step(input string tag, input logic [6:0] ctl,
                      input logic [NS-1:0] fd = '0, input logic [2*NS-1:0] fe = '0,
                      input logic [1:0] hi = 2'b00, input logic [1:0] lo = 2'b00);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.fd = fd; e.fe = fe; e.hi = hi; e.lo = lo;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic clr();
    SrcD = '0; SrcE = '0; BranchD = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    LoadE = 0; LoadM = 0; MfhiE = 0; MfloE = 0; HIWriteM = 0; HIWriteW = 0;
    LOWriteM = 0; LOWriteW = 0; MduStartE = 0; MduDivE = 0; ExcM = 0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
  endtask

  task automatic setD(input int slot, input logic [4:0] r);
    SrcD[5*slot +: 5] = r;
  endtask

  task automatic setE(input int slot, input logic [4:0] r);
    SrcE[5*slot +: 5] = r;
  endtask

  initial begin
    clr(); rst = 1;
    @(posedge clk); #1;
    step("rst0", IDL);
    step("rst1", IDL);
    rst = 0;
    step("idle", IDL);

    // execute / decode forwarding
    setE(2, 8); WriteRegM = 8; WriteRegW = 8; RegWriteM = 1; RegWriteW = 1;
    step("fwdEm", IDL, 3'b000, 6'b10_00_00);
    setE(2, 0);
    step("fwdEr0", IDL);
    clr(); setE(0, 8); WriteRegM = 8; WriteRegW = 8; RegWriteW = 1;
    step("fwdEw", IDL, 3'b000, 6'b00_00_01);
    clr(); setD(1, 8); WriteRegM = 8; RegWriteM = 1;
    step("fwdD", IDL, 3'b010);

    // HI/LO forwarding
    clr(); MfhiE = 1; HIWriteM = 1; HIWriteW = 1;
    step("hiM", IDL, '0, '0, 2'b01);
    HIWriteM = 0;
    step("hiW", IDL, '0, '0, 2'b10);
    clr(); MfloE = 1; LOWriteM = 1; HIWriteM = 1;
    step("loM", IDL, '0, '0, 2'b00, 2'b01);

    // load-use: one stall cycle, then the load moves on
    clr(); LoadE = 1; WriteRegE = 5; setD(1, 5);
    step("lus", HAZ);
    clr();
    step("lusOff", IDL);
    LoadE = 1;
    step("lusR0", IDL);

    // branch stalls
    clr(); BranchD = 1; setD(2, 7); WriteRegM = 7; LoadM = 1; RegWriteM = 1;
    step("brLoadM", HAZ, 3'b100);
    LoadM = 0;
    step("brNoLoad", IDL, 3'b100);
    clr(); BranchD = 1; RegWriteE = 1;
    step("brR0", IDL);

    // full divide
    clr(); MduStartE = 1; MduDivE = 1;
    for (int k = 0; k <= DC; k++) step($sformatf("div%0d", k), (k == 0) ? MDS0 : MDSB);
    step("divDone", BSY);
    MduStartE = 0;
    step("divIdle", IDL);

    // exception aborts a divide at count 10; restart takes full latency
    MduStartE = 1; MduDivE = 1;
    for (int k = 0; k < 22; k++) step($sformatf("exPre%0d", k), (k == 0) ? MDS0 : MDSB);
    ExcM = 1;
    step("exc", EXCB);
    ExcM = 0;
    for (int k = 0; k <= DC; k++) step($sformatf("rediv%0d", k), (k == 0) ? MDS0 : MDSB);
    step("redivDone", BSY);
    MduStartE = 0;
    step("redivIdle", IDL);

    // multiply masks a branch hazard until DONE
    clr(); BranchD = 1; setD(0, 3); WriteRegE = 3; RegWriteE = 1; MduStartE = 1;
    for (int k = 0; k <= MC; k++) step($sformatf("mulBr%0d", k), (k == 0) ? MDS0 : MDSB);
    step("mulBrDone", HAZB);
    MduStartE = 0;
    step("mulBrIdle", HAZ);

    // reset while busy
    clr(); MduStartE = 1;
    step("rbStart", MDS0);
    step("rbBusy", MDSB);
    MduStartE = 0; rst = 1;
    step("rbRst", BSY);
    rst = 0;
    step("rbIdle", IDL);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_sb.md
# hazard_sb

Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline, replacing the fixed two-source combinational hazard unit. It adds:
- N register-source operands per instruction.
- An internal cycle-counting scoreboard for the multiply/divide unit, so the divider no longer needs an external ready signal.
- Exception-driven flushing with MDU abort.
- A bubble into M while E is held.

It sits beside the datapath and drives every stage's stall/flush/forward selects.

## Interface
- NUM_SRC, 2: register source operands per instruction (≥1)
- DIV_CYCLES, 32: divide latency in cycles (≥1)
- MUL_CYCLES, 4: multiply latency in cycles (≥1)
- clk  in  1  clock; one clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- SrcD  in  5*NUM_SRC  decode source register numbers, slot i at [5i+4:5i]
- SrcE  in  5*NUM_SRC  execute source register numbers
- BranchD  in  1  branch resolved in decode
- WriteRegE/M/W  in  5 each  destination register per stage
- RegWriteE/M/W  in  1 each  destination write enable per stage
- LoadE, LoadM  in  1 each  instruction is a memory load
- MfhiE, MfloE  in  1 each  execute instruction reads HI / LO
- HIWriteM/W, LOWriteM/W  in  1 each  HI/LO write pending in M/W
- MduStartE  in  1  MDU instruction present in E (level, held while stalled)
- MduDivE  in  1  1 = divide, 0 = multiply
- ExcM  in  1  exception taken in M
- StallF, StallD, StallE  out  1 each
- FlushD, FlushE, FlushM  out  1 each
- ForwardD  out  NUM_SRC  bit i: forward M result to decode slot i
- ForwardE  out  2*NUM_SRC  slot i at [2i+1:2i]: 00 regfile, 10 from M, 01 from W
- ForwardHIE, ForwardLOE  out  2 each  00 register, 01 from M, 10 from W
- MduBusy  out  1  MDU FSM not IDLE

## Operation
- Decode forwarding: ForwardD[i] = SrcD_i≠0 & SrcD_i==WriteRegM & RegWriteM.
- Execute forwarding per slot: register 0 is never forwarded. Select 10 if matches WriteRegM & RegWriteM, else 01 if matches WriteRegW & RegWriteW, else 00. M wins when both match.
- HI/LO forwarding: if MfhiE, select 01 when HIWriteM, else 10 when HIWriteW. LO is the same using MfloE/LOWriteM/LOWriteW.
- Load-use stall (LuS): LoadE & WriteRegE≠0 & any SrcD_i==WriteRegE. The comparison uses WriteRegE, not a source field.
- Branch stall (BrS): BranchD & any SrcD_i≠0 matching either:
  - WriteRegE with RegWriteE, or
  - WriteRegM with LoadM.
- MDU FSM states IDLE, BUSY, DONE with down-counter Cnt, width clog2(max latency):
  - IDLE & MduStartE: Cnt←(MduDivE?DIV_CYCLES:MUL_CYCLES)−1, go to BUSY.
  - BUSY: Cnt decrements. When Cnt==0, go to DONE.
  - DONE: go to IDLE.
  - MdS (MDU stall) = MduStartE & state≠DONE.
- Output priority:
  1. ExcM: FlushD=FlushE=FlushM=1, all stalls 0. FSM is forced to IDLE next cycle.
  2. Else MdS: StallF=StallD=StallE=1, FlushM=1, FlushE=0. LuS/BrS are masked because they are re-evaluated once MdS drops.
  3. Else LuS|BrS: StallF=StallD=1, FlushE=1.
  4. Else all stall/flush outputs 0.
- MduBusy = (state≠IDLE).

## Timing
- All forwards, stalls and flushes are combinational from inputs plus FSM state. The FSM and Cnt are the only registers.
- Reset: state IDLE, Cnt 0, MduBusy 0. With inputs idle, every output is 0.
- MDU op of latency L entering E at cycle 0:
  - Stalled cycles 0..L (L+1 cycles).
  - Cycle L+1 is DONE: no stall, and the op advances to M.
  - FSM returns to IDLE at L+2.
- Back-to-back MDU ops: the second enters E while the FSM is in DONE→IDLE and starts from IDLE. No lost or merged operation.
- ExcM during BUSY aborts the count. If a new MduStartE arrives one cycle later, it restarts with full latency.
- rst during BUSY returns to IDLE on that edge. The stall drops the same cycle if MduStartE is low.

## Structure
- hazard_pkg holds:
  - REG_W=5.
  - Forward encodings FWD_NONE/FWD_M/FWD_W.
  - HI/LO encodings HL_NONE/HL_M/HL_W.
  - MDU state enum.
- Sub-module mdu_stall_ctr (FSM + Cnt; in: start, div, abort; out: stall, busy).
- The top level holds the generate-loop comparators per source slot and the priority mux.

## Test plan
- NUM_SRC=3, SrcE slot 2=8, WriteRegM=8, WriteRegW=8, both RegWrite → ForwardE[5:4]=10. Same with SrcE slot 2=0 → 00.
- LoadE, WriteRegE=5, SrcD slot1=5 → StallF=StallD=FlushE=1 for exactly one cycle.
- DIV_CYCLES=32, MduStartE held with MduDivE=1 → StallE high 33 cycles, FlushM=1 throughout. Cycle 34: no stall, MduBusy=1. Cycle 35: MduBusy=0.
- Divide busy at count 10, ExcM=1 → FlushD/E/M=1 and stalls 0 that cycle. Next cycle MduBusy=0.
- MUL_CYCLES=4 multiply while BranchD hazard is present → FlushE stays 0 for 5 cycles, then BrS stall/flush asserts.
- MfhiE with HIWriteM and HIWriteW → ForwardHIE=01. HIWriteW only → 10.
